// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and defaults for the pipeline hazard controller
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN           = 2'd0,
        FETCH_WAIT    = 2'd1,
        REDIRECT_PEND = 2'd2
    } ctrl_state_t;

    localparam int DEFAULT_REG_ADDR_W = 5;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter for performance debug
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - PC/IF-ID/ID-EX stall, flush and bubble control
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_memread_i,
    input  logic                  branch_taken_i,
    input  logic                  imem_ready_i,
    output logic                  pc_write_o,
    output logic                  if_id_stall_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_bubble_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o,
    output logic [1:0]            state_o
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    logic        hazard;

    assign hazard = ex_memread_i && (ex_rd_i != '0) &&
                    ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Illegal encoding 3 falls through the RUN/FETCH_WAIT path and lands in RUN.
    always_comb begin
        pc_write_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        state_d        = state_q;
        if (rst_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
            state_d        = RUN;
        end else if (state_q == REDIRECT_PEND) begin
            if_id_flush_o = 1'b1;
            if (imem_ready_i) begin
                state_d = RUN;
            end
        end else if (hazard) begin
            if_id_stall_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
            state_d        = (state_q == FETCH_WAIT) ? FETCH_WAIT : RUN;
        end else if (branch_taken_i) begin
            pc_write_o    = 1'b1;
            if_id_flush_o = 1'b1;
            state_d       = imem_ready_i ? RUN : REDIRECT_PEND;
        end else if (!imem_ready_i) begin
            if_id_flush_o = 1'b1;
            state_d       = FETCH_WAIT;
        end else begin
            pc_write_o = 1'b1;
            state_d    = RUN;
        end
    end

    assign state_o = rst_i ? 2'd0 : state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (if_id_stall_o),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (if_id_flush_o),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int SMALL_W = 2;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
    logic       id_uses_rs2_i, ex_memread_i, branch_taken_i, imem_ready_i;

    logic        pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;
    logic [1:0]  state_o;

    logic               s_pc_write, s_stall, s_flush, s_bubble;
    logic [SMALL_W-1:0] s_stall_cnt, s_flush_cnt;
    logic [1:0]         s_state;

    always #5 clk_i = ~clk_i;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_uses_rs2_i(id_uses_rs2_i),
        .ex_rd_i(ex_rd_i), .ex_memread_i(ex_memread_i),
        .branch_taken_i(branch_taken_i), .imem_ready_i(imem_ready_i),
        .pc_write_o(pc_write_o), .if_id_stall_o(if_id_stall_o),
        .if_id_flush_o(if_id_flush_o), .id_ex_bubble_o(id_ex_bubble_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .state_o(state_o)
    );

    // Narrow-counter instance sharing the same stimulus exercises saturation.
    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(SMALL_W)) dut_s (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_uses_rs2_i(id_uses_rs2_i),
        .ex_rd_i(ex_rd_i), .ex_memread_i(ex_memread_i),
        .branch_taken_i(branch_taken_i), .imem_ready_i(imem_ready_i),
        .pc_write_o(s_pc_write), .if_id_stall_o(s_stall),
        .if_id_flush_o(s_flush), .id_ex_bubble_o(s_bubble),
        .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt), .state_o(s_state)
    );

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       uses2;
        logic [4:0] rd;
        logic       mr, br, rdy;
        logic       e_pc, e_stall, e_flush, e_bub;
        logic [1:0] e_next;
    } vec_t;

    vec_t vecs[19];

    int n_checks = 0;
    int n_fail   = 0;

    bit     m_redirect, m_waiting;
    longint m_stall, m_flush;
    logic   e_pc, e_stall, e_flush, e_bub;
    logic [1:0] e_state;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_outputs();
        bit hz;
        hz = ex_memread_i && (ex_rd_i != 0) &&
             ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));
        if (rst_i)             {e_pc, e_stall, e_flush, e_bub} = 4'b0011;
        else if (m_redirect)   {e_pc, e_stall, e_flush, e_bub} = 4'b0010;
        else if (hz)           {e_pc, e_stall, e_flush, e_bub} = 4'b0101;
        else if (branch_taken_i) {e_pc, e_stall, e_flush, e_bub} = 4'b1010;
        else if (!imem_ready_i)  {e_pc, e_stall, e_flush, e_bub} = 4'b0010;
        else                   {e_pc, e_stall, e_flush, e_bub} = 4'b1000;
        e_state = rst_i ? 2'd0 : m_redirect ? 2'd2 : m_waiting ? 2'd1 : 2'd0;
    endtask

    task automatic model_advance();
        if (rst_i) begin
            m_redirect = 0; m_waiting = 0; m_stall = 0; m_flush = 0;
        end else begin
            m_stall += longint'(e_stall);
            m_flush += longint'(e_flush);
            if (m_redirect) begin
                if (imem_ready_i) m_redirect = 0;
            end else if (e_stall) begin
                // hazard: nothing moves
            end else if (branch_taken_i) begin
                m_redirect = !imem_ready_i;
                m_waiting  = 0;
            end else begin
                m_waiting = !imem_ready_i;
            end
        end
    endtask

    // Inputs are already applied; sample mid-cycle, clock, then check registered state.
    task automatic run_cycle(input bit use_vec, input vec_t v);
        @(negedge clk_i);
        model_outputs();
        check("pc_write", pc_write_o, e_pc);
        check("stall", if_id_stall_o, e_stall);
        check("flush", if_id_flush_o, e_flush);
        check("bubble", id_ex_bubble_o, e_bub);
        check("state", state_o, e_state);
        check("excl", if_id_stall_o & if_id_flush_o, 1'b0);
        if (use_vec) begin
            check("vec_pc", pc_write_o, v.e_pc);
            check("vec_stall", if_id_stall_o, v.e_stall);
            check("vec_flush", if_id_flush_o, v.e_flush);
            check("vec_bubble", id_ex_bubble_o, v.e_bub);
        end
        @(posedge clk_i);
        model_advance();
        #1;
        check("stall_cnt", stall_cnt_o, m_stall);
        check("flush_cnt", flush_cnt_o, m_flush);
        check("sat_stall_cnt", s_stall_cnt, sat(m_stall, SMALL_W));
        check("sat_flush_cnt", s_flush_cnt, sat(m_flush, SMALL_W));
        if (use_vec) check("vec_next_state", state_o, v.e_next);
    endtask

    task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic mr,
                         input logic br, input logic rdy);
        rst_i = r; id_rs1_i = rs1; id_rs2_i = rs2; id_uses_rs2_i = u2;
        ex_rd_i = rd; ex_memread_i = mr; branch_taken_i = br; imem_ready_i = rdy;
    endtask

    initial begin
        vec_t none;
        none = '{default: '0};
        vecs[0]  = '{5, 0, 0, 5, 1, 0, 1, 0, 1, 0, 1, 0};
        vecs[1]  = '{5, 0, 0, 5, 0, 0, 1, 1, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0};
        vecs[3]  = '{3, 7, 0, 7, 1, 0, 1, 1, 0, 0, 0, 0};
        vecs[4]  = '{3, 7, 1, 7, 1, 0, 1, 0, 1, 0, 1, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 2};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2};
        vecs[8]  = '{4, 0, 0, 4, 1, 1, 0, 0, 0, 1, 0, 2};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        vecs[11] = '{6, 0, 0, 6, 1, 1, 1, 0, 1, 0, 1, 0};
        vecs[12] = '{6, 0, 0, 6, 0, 1, 0, 1, 0, 1, 0, 2};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
        vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
        vecs[15] = '{2, 0, 0, 2, 1, 0, 0, 0, 1, 0, 1, 1};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
        vecs[18] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0};

        m_redirect = 0; m_waiting = 0; m_stall = 0; m_flush = 0;

        // Reset: two cycles with reset outputs, counters cleared after the first edge.
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        run_cycle(0, none);
        run_cycle(0, none);
        check("reset_stall_cnt", stall_cnt_o, 0);

        // Directed table.
        foreach (vecs[i]) begin
            drive(0, vecs[i].rs1, vecs[i].rs2, vecs[i].uses2, vecs[i].rd,
                  vecs[i].mr, vecs[i].br, vecs[i].rdy);
            run_cycle(1, vecs[i]);
            if (i == 0) check("loaduse_stall_cnt", stall_cnt_o, 1);
        end
        check("table_stall_cnt", stall_cnt_o, 4);
        check("table_flush_cnt", flush_cnt_o, 10);
        check("table_sat_stall", s_stall_cnt, 3);

        // Reset while a redirect is pending drops it and clears counters.
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        run_cycle(0, none);
        check("pend_state", state_o, 2);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        check("rst_pc", pc_write_o, 0);
        check("rst_stall", if_id_stall_o, 0);
        check("rst_flush", if_id_flush_o, 1);
        check("rst_bubble", id_ex_bubble_o, 1);
        check("rst_state", state_o, 0);
        run_cycle(0, none);
        check("rst_cleared_flush", flush_cnt_o, 0);
        run_cycle(0, none);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk_i);
        check("post_rst_pc", pc_write_o, 1);
        check("post_rst_flush", if_id_flush_o, 0);
        run_cycle(0, none);

        // Randomised traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 59) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 2) != 0));
            run_cycle(0, none);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline control unit for the 5-stage core: decides each cycle whether the PC advances, whether the IF/ID register holds (stall) or loads a NOP (flush), and whether a bubble enters ID/EX. Handles load-use hazards, taken branches resolved in ID, and a multi-cycle instruction fetch, including a taken branch that arrives while a fetch is still in flight. Sits beside the IF/ID and ID/EX registers and drives their stall/flush inputs and the PC write enable. Also keeps saturating stall and flush counters for performance debug.

## Interface
- REG_ADDR_W, 5: register index width
- CNT_W, 32: performance counter width

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- id_rs1_i  in  REG_ADDR_W  rs1 of instruction in IF/ID
- id_rs2_i  in  REG_ADDR_W  rs2 of instruction in IF/ID
- id_uses_rs2_i  in  1  ID instruction reads rs2
- ex_rd_i  in  REG_ADDR_W  rd of instruction in ID/EX
- ex_memread_i  in  1  ID/EX instruction is a load
- branch_taken_i  in  1  branch in ID resolved taken this cycle
- imem_ready_i  in  1  instruction memory returns valid fetch this cycle
- pc_write_o  out  1  PC register load enable
- if_id_stall_o  out  1  IF/ID hold
- if_id_flush_o  out  1  IF/ID loads zero (NOP)
- id_ex_bubble_o  out  1  zero control fields into ID/EX
- stall_cnt_o  out  CNT_W  cycles with if_id_stall_o=1, saturating
- flush_cnt_o  out  CNT_W  cycles with if_id_flush_o=1, saturating
- state_o  out  2  current FSM state

## Operation
- hazard = ex_memread_i & (ex_rd_i != 0) & ((ex_rd_i == id_rs1_i) | (id_uses_rs2_i & ex_rd_i == id_rs2_i)).
- States: RUN=0, FETCH_WAIT=1, REDIRECT_PEND=2. Value 3 is illegal and is treated as RUN.
- Outputs are combinational from state and inputs. They follow this priority, highest first:
  - REDIRECT_PEND: pc_write=0, flush=1, stall=0, bubble=0. hazard and branch_taken_i are ignored. If imem_ready_i=1, next state is RUN; otherwise stay.
  - hazard (RUN or FETCH_WAIT): pc_write=0, stall=1, flush=0, bubble=1. Next state is unchanged. A fetch completing in this cycle is discarded, and the same PC is refetched.
  - branch_taken_i (RUN or FETCH_WAIT): pc_write=1, flush=1, stall=0, bubble=0. If imem_ready_i=0, the in-flight fetch is wrong-path and next state is REDIRECT_PEND; otherwise next state is RUN.
  - !imem_ready_i: pc_write=0, flush=1, stall=0, bubble=0. Next state is FETCH_WAIT.
  - Otherwise: pc_write=1, all other outputs 0, next state RUN.
- stall and flush are never both 1.
- Counters increment by 1 on each edge where the corresponding output is 1, and hold at 2^CNT_W-1.

## Timing
- Output latency is zero: outputs respond to inputs in the same cycle. State and counters update on the next rising edge.
- While rst_i=1: pc_write_o=0, if_id_stall_o=0, if_id_flush_o=1, id_ex_bubble_o=1, state_o=0. The first edge with rst_i=1 clears the counters to 0.
- A load-use stall lasts exactly 1 cycle per hazard, because the bubbled ID/EX then carries rd=0.
- Branch penalty: 1 flushed cycle when imem_ready_i=1. With a fetch in flight, the penalty is 1 + N cycles, where N is the number of cycles until imem_ready_i.
- Reset mid-operation: a pending redirect is dropped. The first cycle after rst_i falls evaluates from RUN.

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - the ctrl_state_t enum (RUN, FETCH_WAIT, REDIRECT_PEND) and its 2-bit encodings;
  - the default REG_ADDR_W.
- One sub-module, sat_counter (parameter W; inputs clk_i, rst_i, inc_i; output cnt_o), instantiated twice for the stall and flush counters.

## Test plan
- Load-use: ex_memread_i=1, ex_rd_i=5, id_rs1_i=5, imem_ready_i=1 for 1 cycle, then ex_memread_i=0 -> one cycle with stall=1, bubble=1, pc_write=0, then normal; stall_cnt_o=1.
- rd=x0 and unused rs2: ex_rd_i=0 matching rs1, then ex_rd_i=7 = id_rs2_i with id_uses_rs2_i=0 -> no stall in either case.
- Branch with fetch ready: branch_taken_i=1, imem_ready_i=1 -> pc_write=1, flush=1 for 1 cycle, state stays RUN; flush_cnt_o=1.
- Branch during in-flight fetch: branch_taken_i=1 with imem_ready_i=0, then ready held low 2 more cycles, then high -> state goes RUN→2→2→2→RUN; flush=1 for 4 cycles; pc_write=1 only in the first of those cycles.
- Priority: hazard and branch_taken_i both 1 -> stall=1, flush=0, pc_write=0. Next cycle branch_taken_i=1 alone -> redirect.
- Reset: assert rst_i in REDIRECT_PEND with nonzero counters -> after the edge, state_o=0 and counters are 0; outputs hold the reset values while rst_i=1. Separately, preload a counter to 2^CNT_W-2 via a forced value and run 3 stall cycles -> the counter saturates.
